// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan controller with a refresh prescaler,
// frame-synchronous shadow loading, leading-zero suppression and PWM brightness.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned DIV      = 20000,
  parameter int unsigned BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [7:0]            seg,
  output logic                  pending,
  output logic                  frame
);

  localparam int unsigned PH_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned PW    = $clog2(DIV) + BRIGHT_W + 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [PH_W-1:0]   phase;
  logic [IDX_W-1:0]  idx;
  logic [VAL_W-1:0]  hold_val;
  logic [DIGITS-1:0] hold_dp;
  logic [VAL_W-1:0]  shadow_val;
  logic [DIGITS-1:0] shadow_dp;

  logic              last_phase;
  logic              boundary;
  logic [DIGITS-1:0] lz_mask;
  logic              zero_run;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic              cur_lz;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     on_cycles;
  logic              phase_on;
  logic              drive;
  logic [DIGITS-1:0] digit_sel_nxt;
  logic [7:0]        seg_nxt;
  logic              frame_nxt;

  // Active-low {g,f,e,d,c,b,a} hex glyphs.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign last_phase = (phase == PH_W'(DIV - 1));
  assign boundary   = last_phase && (idx == IDX_W'(DIGITS - 1));

  // Scan counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
      idx   <= '0;
    end else if (last_phase) begin
      phase <= '0;
      idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      phase <= phase + PH_W'(1);
    end
  end

  // Holding register plus shadow, swapped only at the frame boundary so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_val   <= '0;
      hold_dp    <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        hold_val <= value;
        hold_dp  <= dp;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          shadow_val <= value;
          shadow_dp  <= dp;
        end else if (pending) begin
          shadow_val <= hold_val;
          shadow_dp  <= hold_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero run from the most significant digit down; digit 0 always stays lit.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      zero_run   = zero_run & (shadow_val[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = shadow_val[4*i +: 4];
        cur_dp    = shadow_dp[i];
        cur_blank = blank_mask[i];
        cur_lz    = lz_mask[i];
      end
    end
  end

  // PWM window and next output values.
  always_comb begin
    prod          = (PW'(bright) + PW'(1)) * PW'(DIV);
    on_cycles     = prod >> BRIGHT_W;
    phase_on      = (PW'(phase) < on_cycles);
    drive         = phase_on && !cur_blank && !(lz_en && cur_lz);
    digit_sel_nxt = '1;
    seg_nxt       = 8'hFF;
    frame_nxt     = (phase == '0) && (idx == '0);
    if (drive) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        digit_sel_nxt[i] = (idx != IDX_W'(i));
      end
      seg_nxt = {~cur_dp, hex_glyph(cur_nib)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_sel <= '1;
      seg       <= 8'hFF;
      frame     <= 1'b0;
    end else begin
      digit_sel <= digit_sel_nxt;
      seg       <= seg_nxt;
      frame     <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a cycle-count reference model
// with directed scenarios for loading, suppression, PWM and reset.
module tb_seg7_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int DIV      = 4;
  localparam int BRIGHT_W = 2;
  localparam int FRAME    = DIGITS * DIV;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                load = 1'b0;
  logic [4*DIGITS-1:0] value = '0;
  logic [DIGITS-1:0]   dp = '0;
  logic [DIGITS-1:0]   blank_mask = '0;
  logic                lz_en = 1'b0;
  logic [BRIGHT_W-1:0] bright = '1;
  logic [DIGITS-1:0]   digit_sel;
  logic [7:0]          seg;
  logic                pending;
  logic                frame;

  int total = 0;
  int bad   = 0;

  // Reference state: edges since reset, plus the held and displayed words.
  int                  n;
  logic [4*DIGITS-1:0] m_hold_v, m_shadow_v;
  logic [DIGITS-1:0]   m_hold_dp, m_shadow_dp;
  bit                  m_pend;

  string seg_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BRIGHT_W(BRIGHT_W)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp),
    .blank_mask(blank_mask), .lz_en(lz_en), .bright(bright),
    .digit_sel(digit_sel), .seg(seg), .pending(pending), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (n=%0d)", tag, got, exp, n);
    end
  endtask

  // Build the active-low pattern from the list of lit segment letters.
  function automatic logic [6:0] glyph(input int d);
    logic [6:0] g;
    string s;
    g = 7'h7F;
    s = seg_tbl[d];
    for (int k = 0; k < s.len(); k++) g[int'(s[k]) - 97] = 1'b0;
    return g;
  endfunction

  task automatic model_reset();
    n = 0;
    m_hold_v = '0; m_hold_dp = '0;
    m_shadow_v = '0; m_shadow_dp = '0;
    m_pend = 1'b0;
  endtask

  // One clock: predict outputs from the pre-edge state, advance the model, compare.
  task automatic step();
    int ph, slot, top, on_c, nib;
    bit lit, bnd;
    logic [DIGITS-1:0] e_sel;
    logic [7:0] e_seg;
    bit e_frame;
    ph   = n % DIV;
    slot = (n / DIV) % DIGITS;
    top  = 0;
    for (int i = 0; i < DIGITS; i++)
      if (((m_shadow_v >> (4*i)) & 16'hF) != 0) top = i;
    nib  = int'((m_shadow_v >> (4*slot)) & 16'hF);
    on_c = ((int'(bright) + 1) * DIV) / (1 << BRIGHT_W);
    lit  = (ph < on_c) && !blank_mask[slot] && !(lz_en && slot > top);
    e_sel = '1;
    e_seg = 8'hFF;
    if (lit) begin
      e_sel[slot] = 1'b0;
      e_seg = {~m_shadow_dp[slot], glyph(nib)};
    end
    e_frame = (n % FRAME) == 0;
    bnd = (n % FRAME) == FRAME - 1;
    if (bnd) begin
      if (load) begin m_shadow_v = value; m_shadow_dp = dp; end
      else if (m_pend) begin m_shadow_v = m_hold_v; m_shadow_dp = m_hold_dp; end
      m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin m_hold_v = value; m_hold_dp = dp; end
    @(posedge clk);
    #1;
    n++;
    check("digit_sel", 32'(digit_sel), 32'(e_sel));
    check("seg", 32'(seg), 32'(e_seg));
    check("frame", 32'(frame), 32'(e_frame));
    check("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  // Advance until the model sits at the given position within the frame.
  task automatic run_until(input int pos);
    for (int k = 0; k < 2 * FRAME && (n % FRAME) != pos; k++) step();
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_sel", 32'(digit_sel), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_frame", 32'(frame), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Idle scan at full brightness.
    step();
    check("first_sel", 32'(digit_sel), 32'hE);
    check("first_seg", 32'(seg), 32'hC0);
    run(40);

    // Mid-frame load waits for the boundary.
    run_until(6);
    load_once(16'h12A4, 4'b0010);
    check("mid_pending", 32'(pending), 32'h1);
    run_until(1);
    check("new_frame", 32'(frame), 32'h1);
    check("new_d0", 32'(seg), 32'h99);
    run(20);

    // Leading-zero suppression.
    lz_en = 1'b1;
    load_once(16'h0030, 4'b0000);
    run(36);
    load_once(16'h0000, 4'b0000);
    run(36);
    lz_en = 1'b0;

    // Brightness and blanking.
    bright = 2'd0; run(20);
    bright = 2'd2; run(20);
    blank_mask = 4'b0100; run(20);
    blank_mask = '0;
    bright = 2'd3;

    // Load exactly on the boundary cycle, then two loads within one frame.
    run_until(FRAME - 1);
    load_once(16'hBEEF, 4'b0000);
    check("bnd_pending", 32'(pending), 32'h0);
    step();
    check("bnd_frame", 32'(frame), 32'h1);
    check("bnd_seg", 32'(seg), 32'h8E);
    run_until(3);
    load_once(16'h1111, 4'b1111);
    run_until(8);
    load_once(16'h2222, 4'b0000);
    run(40);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      value      = 16'($urandom);
      dp         = 4'($urandom);
      load       = ($urandom_range(0, 7) == 0);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_en      = 1'($urandom);
      bright     = 2'($urandom);
      if ($urandom_range(0, 4) == 0) value[15:8] = 8'h00;
      step();
    end
    load = 1'b0; lz_en = 1'b0; blank_mask = '0; bright = 2'd3;
    run(4);

    // Asynchronous reset during slot 2 with a pending value.
    run_until(9);
    load_once(16'h5555, 4'b1111);
    check("pre_rst_pending", 32'(pending), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_sel", 32'(digit_sel), 32'hF);
    check("arst_seg", 32'(seg), 32'hFF);
    check("arst_pending", 32'(pending), 32'h0);
    check("arst_frame", 32'(frame), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    step();
    check("rel_sel", 32'(digit_sel), 32'hE);
    check("rel_seg", 32'(seg), 32'hC0);
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
